// File: rtl/instr_fetch_pkg.sv
// Shared types and widths for the instruction fetch stage.
// Entries pair an instruction word with the PC it was fetched from.
package instr_fetch_pkg;

  localparam int WORD_LEN   = 32;
  localparam int OPCODE_LEN = 6;
  localparam int FUNCT_LEN  = 6;

  localparam logic [WORD_LEN-1:0] RESET_PC_DEF = '0;

  typedef enum logic {
    S_FETCH,
    S_DISCARD
  } fetch_state_e;

  typedef struct packed {
    logic [WORD_LEN-1:0] pc;
    logic [WORD_LEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [WORD_LEN-1:0] word_align(
    input logic [WORD_LEN-1:0] a
  );
    return {a[WORD_LEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_fifo.sv
// Small synchronous FIFO of {PC, instr} entries.
// Flush wins over push and pop in the same cycle.
module instr_fifo
  import instr_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t data_i,
  output fetch_entry_t data_o,
  output logic [CW-1:0] count_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop)
        rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC, request FSM and instruction buffer.
// Redirects flush the buffer; an in-flight beat is dropped.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [WORD_LEN-1:0] RESET_PC   = RESET_PC_DEF,
  parameter int                  FIFO_DEPTH = 2
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  output logic                  IMemReq,
  output logic [WORD_LEN-1:0]   IMemAddr,
  input  logic                  IMemAck,
  input  logic [WORD_LEN-1:0]   IMemData,
  input  logic                  Redirect,
  input  logic [WORD_LEN-1:0]   RedirectPC,
  input  logic                  InstrReady,
  output logic                  InstrValid,
  output logic [WORD_LEN-1:0]   Instr,
  output logic [WORD_LEN-1:0]   InstrPC,
  output logic [OPCODE_LEN-1:0] OpCode,
  output logic [FUNCT_LEN-1:0]  Funct
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  fetch_state_e        state_q, state_d;
  logic [WORD_LEN-1:0] pc_q, pc_d;
  logic [WORD_LEN-1:0] tgt_q, tgt_d;
  logic                req_q, req_d;

  logic                acked;
  logic                pend;
  logic                push;
  logic                pop;
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       cnt_nxt;
  logic                full;
  logic                empty;
  fetch_entry_t        head;
  fetch_entry_t        beat;

  assign acked = req_q && IMemAck;
  assign pend  = req_q && !IMemAck;
  assign pop   = InstrValid && InstrReady && !Redirect;
  assign beat  = '{pc: pc_q, instr: IMemData};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    push    = 1'b0;
    unique case (1'b1)
      Redirect && pend: begin
        state_d = S_DISCARD;
        tgt_d   = word_align(RedirectPC);
      end
      Redirect && !pend: begin
        state_d = S_FETCH;
        pc_d    = word_align(RedirectPC);
      end
      !Redirect && acked && (state_q == S_DISCARD): begin
        state_d = S_FETCH;
        pc_d    = tgt_q;
      end
      !Redirect && acked && (state_q == S_FETCH): begin
        push = !full || pop;
        pc_d = pc_q + WORD_LEN'(4);
      end
      default: ;
    endcase
  end

  // Budget counts the beat about to land so zero-wait memory streams.
  always_comb begin
    if (Redirect)
      cnt_nxt = '0;
    else
      cnt_nxt = cnt + CW'(push) - CW'(pop);
    if (pend)
      req_d = 1'b1;
    else
      req_d = (state_d == S_FETCH) && (cnt_nxt < DEPTH_C);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      req_q   <= req_d;
    end
  end

  instr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk_i   (Clk),
    .rst_ni  (Rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (Redirect),
    .data_i  (beat),
    .data_o  (head),
    .count_o (cnt),
    .full_o  (full),
    .empty_o (empty)
  );

  assign IMemReq    = req_q;
  assign IMemAddr   = pc_q;
  assign InstrValid = !empty;
  assign Instr      = InstrValid ? head.instr : '0;
  assign InstrPC    = InstrValid ? head.pc : '0;
  assign OpCode     = Instr[WORD_LEN-1 -: OPCODE_LEN];
  assign Funct      = Instr[FUNCT_LEN-1:0];

endmodule
